// File: rtl/fanout_pipe_repeater.sv
// rtl/fanout_pipe_repeater.sv - elastic repeater pipeline feeding an eager fork to NUM_LOADS loads
// Each stage is a main/skid register pair; the last stage's main register is broadcast to all loads.
module fanout_pipe_repeater #(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 2,
  parameter int NUM_LOADS = 2,
  localparam int OCC_W    = $clog2(2*STAGES+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic [NUM_LOADS-1:0] out_valid,
  input  logic [NUM_LOADS-1:0] out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [OCC_W-1:0]     occupancy
);

  logic [STAGES-1:0]    main_valid;
  logic [STAGES-1:0]    skid_valid;
  logic [WIDTH-1:0]     main_data [STAGES];
  logic [WIDTH-1:0]     skid_data [STAGES];
  logic [NUM_LOADS-1:0] done;

  logic [STAGES-1:0]    up_valid;
  logic [STAGES-1:0]    down_ready;
  logic [STAGES-1:0]    take_in;
  logic [STAGES-1:0]    take_out;
  logic [WIDTH-1:0]     up_data [STAGES];
  logic                 last_valid;
  logic                 retire;
  logic                 in_fire;

  // Ready depends only on the registered skid flag, never on downstream ready.
  assign in_ready   = !skid_valid[0] && !reset;
  assign in_fire    = in_valid && in_ready;
  assign last_valid = main_valid[STAGES-1];
  assign out_valid  = last_valid ? ~done : '0;
  assign out_data   = last_valid ? main_data[STAGES-1] : '0;
  assign retire     = last_valid && (&(done | out_ready));

  always_comb begin
    up_valid   = '0;
    down_ready = '0;
    for (int k = 0; k < STAGES; k++) begin
      up_data[k] = '0;
    end
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int k = 1; k < STAGES; k++) begin
      up_valid[k] = main_valid[k-1];
      up_data[k]  = main_data[k-1];
    end
    for (int k = 0; k < STAGES-1; k++) begin
      down_ready[k] = !skid_valid[k+1];
    end
    down_ready[STAGES-1] = retire;
    take_in  = up_valid & ~skid_valid;
    take_out = main_valid & down_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= '0;
      skid_valid <= '0;
      done       <= '0;
      occupancy  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        main_data[k] <= '0;
        skid_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (take_out[k]) begin
          // A full skid blocks take_in, so refilling main from skid never races an arrival.
          if (skid_valid[k]) begin
            main_data[k]  <= skid_data[k];
            skid_valid[k] <= 1'b0;
          end else begin
            main_valid[k] <= take_in[k];
            if (take_in[k]) begin
              main_data[k] <= up_data[k];
            end
          end
        end else if (take_in[k]) begin
          if (main_valid[k]) begin
            skid_valid[k] <= 1'b1;
            skid_data[k]  <= up_data[k];
          end else begin
            main_valid[k] <= 1'b1;
            main_data[k]  <= up_data[k];
          end
        end
      end
      done      <= retire ? '0 : (done | (out_valid & out_ready));
      occupancy <= occupancy + OCC_W'(in_fire) - OCC_W'(retire);
    end
  end

endmodule

// File: tb/tb_fanout_pipe_repeater.sv
// tb/tb_fanout_pipe_repeater.sv - directed and randomised checks of fanout_pipe_repeater
module tb_fanout_pipe_repeater;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic       m_in_valid, m_in_ready;
  logic [7:0] m_in_data, m_out_data;
  logic [1:0] m_out_valid, m_out_ready;
  logic [2:0] m_occ;

  logic       s_in_valid, s_in_ready;
  logic [0:0] s_in_data, s_out_data, s_out_valid, s_out_ready;
  logic [1:0] s_occ;

  logic        b_in_valid, b_in_ready;
  logic [63:0] b_in_data, b_out_data;
  logic [15:0] b_out_valid, b_out_ready;
  logic [4:0]  b_occ;

  fanout_pipe_repeater #(.WIDTH(8), .STAGES(2), .NUM_LOADS(2)) u_main (
    .clk(clk), .reset(reset), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data), .occupancy(m_occ)
  );

  fanout_pipe_repeater #(.WIDTH(1), .STAGES(1), .NUM_LOADS(1)) u_small (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .occupancy(s_occ)
  );

  fanout_pipe_repeater #(.WIDTH(64), .STAGES(8), .NUM_LOADS(16)) u_big (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .occupancy(b_occ)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:0] s_pat(int n);
    return 1'((n % 3) == 1);
  endfunction

  function automatic logic [63:0] b_pat(int n);
    return {32'(n) * 32'h9E37_79B1, 32'(n) ^ 32'h5A5A_0000};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    m_in_valid = 1'b0; m_in_data = '0; m_out_ready = '0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = '0;
    repeat (2) tick();
    checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_held: got %b want 0", m_in_ready); end
    checks++; if (m_out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid: got %b want 00", m_out_valid); end
    checks++; if (m_out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", m_out_data); end
    checks++; if (m_occ !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", m_occ); end
    reset = 1'b0;
    #1;
    checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", m_in_ready); end
    checks++; if (s_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_sweep_ready: got %b%b want 11", s_in_ready, b_in_ready); end
  endtask

  task automatic test_single_word();
    logic [1:0] exp_v [3];
    logic [7:0] exp_d [3];
    logic [2:0] exp_o [3];
    exp_v = '{2'b00, 2'b11, 2'b00};
    exp_d = '{8'h00, 8'hA5, 8'h00};
    exp_o = '{3'd1, 3'd1, 3'd0};
    m_out_ready = 2'b11;
    for (int c = 0; c < 3; c++) begin
      m_in_valid = (c == 0);
      m_in_data  = 8'hA5;
      tick();
      checks++; if (m_out_valid !== exp_v[c]) begin errors++; $display("FAIL single_valid[%0d]: got %b want %b", c, m_out_valid, exp_v[c]); end
      checks++; if (m_out_data !== exp_d[c]) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", c, m_out_data, exp_d[c]); end
      checks++; if (m_occ !== exp_o[c]) begin errors++; $display("FAIL single_occ[%0d]: got %0d want %0d", c, m_occ, exp_o[c]); end
    end
    m_in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    logic [1:0] ev;
    logic [7:0] ed;
    logic [2:0] eo;
    m_out_ready = 2'b11;
    for (int c = 0; c < 18; c++) begin
      m_in_valid = (c < 16);
      m_in_data  = 8'(c + 1);
      checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", c, m_in_ready); end
      tick();
      ev = (c >= 1 && c <= 16) ? 2'b11 : 2'b00;
      ed = (c >= 1 && c <= 16) ? 8'(c) : 8'h00;
      eo = (c == 0) ? 3'd1 : (c <= 15) ? 3'd2 : (c == 16) ? 3'd1 : 3'd0;
      checks++; if (m_out_valid !== ev || m_out_data !== ed) begin errors++; $display("FAIL stream_out[%0d]: got %b/%h want %b/%h", c, m_out_valid, m_out_data, ev, ed); end
      checks++; if (m_occ !== eo) begin errors++; $display("FAIL stream_occ[%0d]: got %0d want %0d", c, m_occ, eo); end
    end
    m_in_valid = 1'b0;
  endtask

  task automatic test_staggered_fork();
    int l0 = 0;
    int l1 = 0;
    logic [1:0] rdy [6];
    logic [1:0] exp_v [6];
    logic [7:0] exp_d [6];
    logic [2:0] exp_o [6];
    rdy   = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    exp_v = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00};
    exp_d = '{8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h00};
    exp_o = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
    for (int c = 0; c < 6; c++) begin
      m_out_ready = rdy[c];
      m_in_valid  = (c == 0);
      m_in_data   = 8'h3C;
      if (m_out_valid[0] && m_out_ready[0]) l0++;
      if (m_out_valid[1] && m_out_ready[1]) l1++;
      tick();
      checks++; if (m_out_valid !== exp_v[c] || m_out_data !== exp_d[c]) begin errors++; $display("FAIL stagger_out[%0d]: got %b/%h want %b/%h", c, m_out_valid, m_out_data, exp_v[c], exp_d[c]); end
      checks++; if (m_occ !== exp_o[c]) begin errors++; $display("FAIL stagger_occ[%0d]: got %0d want %0d", c, m_occ, exp_o[c]); end
    end
    m_in_valid = 1'b0;
    checks++; if (l0 !== 1 || l1 !== 1) begin errors++; $display("FAIL stagger_takes: got l0=%0d l1=%0d want 1/1", l0, l1); end
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    int nout = 0;
    m_out_ready = 2'b00;
    m_in_valid  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      m_in_data = 8'h10 + 8'(nacc);
      if (m_in_ready) nacc++;
      tick();
    end
    checks++; if (nacc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", nacc); end
    checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", m_in_ready); end
    checks++; if (m_occ !== 3'd4) begin errors++; $display("FAIL bp_occ: got %0d want 4", m_occ); end
    checks++; if (m_out_valid !== 2'b11 || m_out_data !== 8'h10) begin errors++; $display("FAIL bp_head: got %b/%h want 11/10", m_out_valid, m_out_data); end
    m_out_ready = 2'b11;
    for (int c = 0; c < 12; c++) begin
      m_in_data = 8'h10 + 8'(nacc);
      if (m_in_ready) nacc++;
      checks++; if (m_out_valid !== 2'b11 || m_out_data !== 8'h10 + 8'(nout)) begin errors++; $display("FAIL bp_release[%0d]: got %b/%h want 11/%h", c, m_out_valid, m_out_data, 8'h10 + 8'(nout)); end
      nout++;
      tick();
    end
    m_in_valid = 1'b0;
    for (int c = 0; c < 20 && m_occ != 0; c++) begin
      if (m_out_valid == 2'b11) begin
        checks++; if (m_out_data !== 8'h10 + 8'(nout)) begin errors++; $display("FAIL bp_drain_data: got %h want %h", m_out_data, 8'h10 + 8'(nout)); end
        nout++;
      end
      tick();
    end
    checks++; if (m_occ !== 3'd0 || nout !== nacc) begin errors++; $display("FAIL bp_drain_total: got occ=%0d out=%0d want occ=0 out=%0d", m_occ, nout, nacc); end
  endtask

  task automatic test_reset_mid();
    m_out_ready = 2'b10;
    for (int c = 0; c < 3; c++) begin
      m_in_valid = 1'b1;
      m_in_data  = 8'h50 + 8'(c);
      tick();
    end
    m_in_valid = 1'b0;
    checks++; if (m_occ !== 3'd3 || m_out_valid !== 2'b01 || m_out_data !== 8'h50) begin errors++; $display("FAIL rmid_pre: got occ=%0d v=%b d=%h want 3/01/50", m_occ, m_out_valid, m_out_data); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (m_out_valid !== 2'b00 || m_out_data !== 8'h00) begin errors++; $display("FAIL rmid_out: got %b/%h want 00/00", m_out_valid, m_out_data); end
    checks++; if (m_occ !== 3'd0 || m_in_ready !== 1'b1) begin errors++; $display("FAIL rmid_state: got occ=%0d rdy=%b want 0/1", m_occ, m_in_ready); end
    m_out_ready = 2'b11;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (m_out_valid !== 2'b00 || m_occ !== 3'd0) begin errors++; $display("FAIL rmid_flushed[%0d]: got v=%b occ=%0d want 00/0", c, m_out_valid, m_occ); end
    end
  endtask

  task automatic test_config_sweep();
    int s_tx = 0;
    int s_rx = 0;
    int b_tx = 0;
    int b_rx [16];
    int b_min;
    logic drain;
    foreach (b_rx[i]) b_rx[i] = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      drain = (c >= 300);
      s_in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
      s_in_data   = s_pat(s_tx);
      s_out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
      b_in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
      b_in_data   = b_pat(b_tx);
      b_out_ready = drain ? 16'hFFFF : 16'($urandom());
      @(negedge clk);
      b_min = b_rx[0];
      foreach (b_rx[i]) if (b_rx[i] < b_min) b_min = b_rx[i];
      checks++; if (s_occ !== 2'(s_tx - s_rx) || s_occ > 2'd2) begin errors++; $display("FAIL sweep_small_occ[%0d]: got %0d want %0d", c, s_occ, s_tx - s_rx); end
      checks++; if (b_occ !== 5'(b_tx - b_min) || b_occ > 5'd16) begin errors++; $display("FAIL sweep_big_occ[%0d]: got %0d want %0d", c, b_occ, b_tx - b_min); end
      if (s_out_valid[0] && s_out_ready[0]) begin
        checks++; if (s_out_data !== s_pat(s_rx)) begin errors++; $display("FAIL sweep_small_data[%0d]: got %b want %b", s_rx, s_out_data, s_pat(s_rx)); end
        s_rx++;
      end
      for (int i = 0; i < 16; i++) begin
        if (b_out_valid[i] && b_out_ready[i]) begin
          checks++; if (b_out_data !== b_pat(b_rx[i])) begin errors++; $display("FAIL sweep_big_data load%0d word%0d: got %h want %h", i, b_rx[i], b_out_data, b_pat(b_rx[i])); end
          b_rx[i]++;
        end
      end
      if (s_in_valid && s_in_ready) s_tx++;
      if (b_in_valid && b_in_ready) b_tx++;
    end
    checks++; if (s_rx !== s_tx || s_tx < 20) begin errors++; $display("FAIL sweep_small_total: got rx=%0d tx=%0d want equal and >=20", s_rx, s_tx); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (b_rx[i] !== b_tx) begin errors++; $display("FAIL sweep_big_total load%0d: got %0d want %0d", i, b_rx[i], b_tx); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_streaming();
    test_staggered_fork();
    test_backpressure();
    test_reset_mid();
    test_config_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
